neuron_layer_array: RTL and testbench
=====================================

# neuron_layer_array

Parametrised fully-connected layer slice: NUM_NEURONS neuron lanes share one streamed input vector of NUM_INPUTS fixed-point samples. Each lane holds its own weight memory and bias, loaded over the shared config bus. Each lane runs a saturating multiply-accumulate, adds its bias and applies a selectable activation. The block raises all lane results together behind a valid/ready output handshake with full backpressure. It replaces single-neuron instances wherever a layer's neurons all consume the same input stream.

## Interface
- LAYER_NO, 1: layer index matched against cfg_layer_num.
- NUM_NEURONS, 4: number of lanes; lane i answers cfg_neuron_num == i.
- NUM_INPUTS, 16: samples per frame; also weight depth per lane; ≥2.
- DATA_WIDTH, 16: signed sample/weight/output width.
- INT_BITS, 4: integer bits including sign; FRAC = DATA_WIDTH-INT_BITS.
- ACT_TYPE, "relu": one of "relu", "linear", "leaky".
- LEAK_SHIFT, 3: arithmetic right shift applied to negatives in "leaky".
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_weight_valid  in  1  write cfg_value[DATA_WIDTH-1:0] into the addressed lane's next weight slot.
- cfg_bias_valid  in  1  write cfg_value[DATA_WIDTH-1:0] as the addressed lane's bias.
- cfg_layer_num  in  32  config target layer.
- cfg_neuron_num  in  32  config target lane.
- cfg_value  in  32  config data.
- in_data  in  DATA_WIDTH  signed input sample, Q(INT_BITS.FRAC).
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts sample this cycle.
- out_data  out  NUM_NEURONS*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result vector present.
- out_ready  in  1  downstream accepts.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ACCUM, DRAIN, BIAS, ACT, OUT.
- A sample is accepted on an edge where in_valid & in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 elsewhere.
- IDLE→ACCUM on the first accept. ACCUM→DRAIN on the accept that makes in_cnt reach NUM_INPUTS.
- DRAIN lasts 2 cycles while the read/multiply pipeline empties. Then BIAS (1 cycle), ACT (1 cycle), OUT.
- OUT→IDLE on out_valid & out_ready. Accumulators, in_cnt and the pipeline clear on that edge.
- Pipeline per lane, all lanes in lockstep:
  - Synchronous weight read at address in_cnt, input registered alongside.
  - Signed product of 2*DATA_WIDTH bits, registered.
  - Accumulator of 2*DATA_WIDTH bits.
- Accumulate and bias add saturate. Two same-sign operands whose sum flips sign clamp to the max positive or min negative 2*DATA_WIDTH value.
- Bias is sign-extended and shifted left by FRAC to align with the product format Q(2·INT_BITS.2·FRAC).
- Activation takes acc[FRAC+DATA_WIDTH-1:FRAC]; bits above are checked for signed overflow:
  - relu: negative → 0; positive overflow → 0x7FFF-style max.
  - linear: signed saturation to DATA_WIDTH.
  - leaky: negative values are arithmetically shifted right by LEAK_SHIFT, then saturated.
- Config path, active only when cfg_layer_num == LAYER_NO, cfg_neuron_num < NUM_NEURONS and state == IDLE:
  - A weight write stores at the lane's write pointer, then the pointer increments, wrapping NUM_INPUTS-1→0.
  - A bias write replaces the lane bias.
- Config is ignored in all other cases: other layer, lane out of range, or state ≠ IDLE.
- Simultaneous weight and bias valid: both take effect.

## Timing
- Reset (async assert) values:
  - in_ready = 1, out_valid = 0, out_data = 0, busy = 0, state IDLE.
  - in_cnt, accumulators, biases and write pointers are 0.
  - Weight memory contents are undefined/retained (not cleared).
- Reset mid-frame aborts the frame. No output is produced for it.
- Last sample accepted at edge E: BIAS at E+3, ACT at E+4, out_valid = 1 after edge E+4.
- Input throughput: one sample per cycle, no bubbles required. Gaps in in_valid only stretch ACCUM.
- out_valid/out_data hold stable until the out_ready handshake. out_valid falls and in_ready rises on the handshake edge.
- Minimum frame period is NUM_INPUTS+5 cycles with out_ready tied high.

## Test plan
- NUM_NEURONS=2, NUM_INPUTS=4, DATA_WIDTH=16, INT_BITS=4, relu:
  - Lane0 weights 0x1000×4, bias 0x0800; lane1 weights 0xF000×4, bias 0x0800.
  - Inputs 0x1000, 0x2000, 0x0800, 0x0800 back-to-back.
  - Required: lane0 = 0x4800, lane1 = 0x0000; out_valid 4 edges after the last accept.
- Same config with ACT_TYPE "leaky" and LEAK_SHIFT 3 → lane1 = 0xF900.
- All weights and inputs 0x7FFF, bias 0x7FFF → lane0 = 0x7FFF (saturated). Inputs 0x8000 with weights 0x7FFF under "linear" → 0x8000.
- Backpressure: out_ready held 0 for 10 cycles → out_valid/out_data stable, in_ready 0, in_valid pulses ignored. Release → next frame accepted on the following edge.
- Weight/bias writes issued while busy, or with cfg_layer_num ≠ LAYER_NO, or cfg_neuron_num = 2 → no effect; rerunning frame 1 gives identical results.
- rst_n pulsed low after 2 of 4 samples → outputs take reset values immediately. A fresh 4-sample frame then yields 0x4800 on lane0, with weights retained and bias reloaded to 0x0800 after the reset.

Source files
------------

// File: rtl/neuron_layer_array.sv
// Fully-connected layer slice: NUM_NEURONS lanes run a saturating MAC over one shared input stream.
// Latency: last sample accepted at edge E -> out_valid high after edge E+4 (2 drain, bias, activation).
// Backpressure: in_ready only in IDLE/ACCUM; result vector held stable in OUT until out_ready.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   i_cfg_weight_valid          write i_cfg_value[DATA_WIDTH-1:0] at the addressed lane's weight write pointer
//   i_cfg_bias_valid            write i_cfg_value[DATA_WIDTH-1:0] as the addressed lane's bias
//   i_cfg_layer_num             config target layer (must equal LAYER_NO)
//   i_cfg_neuron_num            config target lane (must be < NUM_NEURONS)
//   i_cfg_value                 config data
//   i_in_data/i_in_valid        signed Q(INT_BITS.FRAC) input sample and its valid
//   o_in_ready                  sample accepted on edges where i_in_valid & o_in_ready
//   o_out_data                  lane i result at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   o_out_valid/i_out_ready     result vector handshake
//   o_busy                      high whenever the block is not idle
module neuron_layer_array #(
    parameter int    LAYER_NO    = 1,
    parameter int    NUM_NEURONS = 4,
    parameter int    NUM_INPUTS  = 16,
    parameter int    DATA_WIDTH  = 16,
    parameter int    INT_BITS    = 4,
    parameter string ACT_TYPE    = "relu",
    parameter int    LEAK_SHIFT  = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_cfg_weight_valid,
    input  logic                              i_cfg_bias_valid,
    input  logic [31:0]                       i_cfg_layer_num,
    input  logic [31:0]                       i_cfg_neuron_num,
    input  logic [31:0]                       i_cfg_value,
    input  logic [DATA_WIDTH-1:0]             i_in_data,
    input  logic                              i_in_valid,
    output logic                              o_in_ready,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] o_out_data,
    output logic                              o_out_valid,
    input  logic                              i_out_ready,
    output logic                              o_busy
);

    localparam int DW   = DATA_WIDTH;
    localparam int FRAC = DATA_WIDTH - INT_BITS;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int AW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CW   = $clog2(NUM_INPUTS + 1);
    // 0 = relu, 1 = linear, 2 = leaky
    localparam int ACT_SEL = (ACT_TYPE == "linear") ? 1 : ((ACT_TYPE == "leaky") ? 2 : 0);

    localparam logic signed [PW-1:0] ACC_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] ACC_MIN = {1'b1, {(PW-1){1'b0}}};
    localparam logic [DW-1:0]        OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_BIAS,
        S_ACT,
        S_OUT
    } state_t;

    // Two same-sign operands whose sum changes sign clamp to the extreme of that sign.
    function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                     input logic signed [PW-1:0] b);
        logic signed [PW-1:0] s;
        s = a + b;
        if ((a[PW-1] == b[PW-1]) && (s[PW-1] != a[PW-1]))
            s = a[PW-1] ? ACC_MIN : ACC_MAX;
        return s;
    endfunction

    // hi holds the bits above the output window plus the window's own sign bit;
    // they must all agree or the value does not fit in DATA_WIDTH.
    function automatic logic [DW-1:0] sat_out(input logic [INT_BITS:0] hi,
                                              input logic [DW-1:0]     mid);
        logic [DW-1:0] r;
        if ((&hi) || !(|hi))
            r = mid;
        else
            r = hi[INT_BITS] ? OUT_MIN : OUT_MAX;
        return r;
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_in_cnt;
    logic            r_drain_cnt;
    logic            r_p1_vld;
    logic            r_p2_vld;
    logic [DW-1:0]   r_x;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_last;
    logic            w_handshake;
    logic            w_cfg_ok;

    assign o_in_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign o_busy      = (r_state != S_IDLE);
    assign o_out_valid = r_out_valid;

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_last      = w_accept && (r_in_cnt == CW'(NUM_INPUTS - 1));
    assign w_handshake = r_out_valid && i_out_ready;
    assign w_cfg_ok    = (r_state == S_IDLE) &&
                         (i_cfg_layer_num == 32'(LAYER_NO)) &&
                         (i_cfg_neuron_num < 32'(NUM_NEURONS));

    generate
        if (DW < 32) begin : g_cfg_unused
            logic w_unused_cfg;
            assign w_unused_cfg = ^i_cfg_value[31:DW];
        end
    endgenerate

    // Control FSM. r_p1_vld/r_p2_vld track samples through the read and
    // multiply stages so input gaps simply leave bubbles in the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_cnt    <= '0;
            r_drain_cnt <= 1'b0;
            r_p1_vld    <= 1'b0;
            r_p2_vld    <= 1'b0;
            r_x         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_p1_vld <= w_accept;
            r_p2_vld <= r_p1_vld;
            if (w_accept) begin
                r_in_cnt <= r_in_cnt + 1'b1;
                r_x      <= i_in_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept)
                        r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_last) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt)
                        r_state <= S_BIAS;
                end
                S_BIAS: begin
                    r_state <= S_ACT;
                end
                S_ACT: begin
                    r_state     <= S_OUT;
                    r_out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (w_handshake) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_cnt    <= '0;
                        r_p1_vld    <= 1'b0;
                        r_p2_vld    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_NEURONS; g++) begin : g_lane
            logic [DW-1:0]        r_wmem [NUM_INPUTS];
            logic [AW-1:0]        r_wptr;
            logic [DW-1:0]        r_bias;
            logic [DW-1:0]        r_w;
            logic signed [PW-1:0] r_prod;
            logic signed [PW-1:0] r_acc;
            logic [DW-1:0]        r_out;

            logic                 w_sel;
            logic signed [PW-1:0] w_w_ext;
            logic signed [PW-1:0] w_x_ext;
            logic signed [PW-1:0] w_bias_ext;
            logic signed [PW-1:0] w_shr;
            logic [DW-1:0]        w_lin;
            logic [DW-1:0]        w_lky;
            logic [DW-1:0]        w_act;
            logic                 w_unused_shr;

            assign w_sel   = w_cfg_ok && (i_cfg_neuron_num == 32'(g));
            assign w_w_ext = {{DW{r_w[DW-1]}}, r_w};
            assign w_x_ext = {{DW{r_x[DW-1]}}, r_x};
            // Bias Q(INT.FRAC) moved up into the product's Q(2INT.2FRAC) format.
            assign w_bias_ext = {{DW{r_bias[DW-1]}}, r_bias} << FRAC;

            assign w_shr        = r_acc >>> LEAK_SHIFT;
            assign w_unused_shr = ^w_shr[FRAC-1:0];
            assign w_lin = sat_out(r_acc[PW-1:FRAC+DW-1], r_acc[FRAC+DW-1:FRAC]);
            assign w_lky = sat_out(w_shr[PW-1:FRAC+DW-1], w_shr[FRAC+DW-1:FRAC]);

            always_comb begin
                w_act = w_lin;
                if ((ACT_SEL == 0) && r_acc[PW-1])
                    w_act = '0;
                else if ((ACT_SEL == 2) && r_acc[PW-1])
                    w_act = w_lky;
            end

            // Weight storage is deliberately not reset so it survives a frame abort.
            always_ff @(posedge clk) begin
                if (w_sel && i_cfg_weight_valid)
                    r_wmem[r_wptr] <= i_cfg_value[DW-1:0];
                if (w_accept)
                    r_w <= r_wmem[r_in_cnt[AW-1:0]];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wptr <= '0;
                    r_bias <= '0;
                    r_prod <= '0;
                    r_acc  <= '0;
                    r_out  <= '0;
                end else begin
                    if (w_sel && i_cfg_weight_valid)
                        r_wptr <= (r_wptr == AW'(NUM_INPUTS - 1)) ? '0 : r_wptr + 1'b1;
                    if (w_sel && i_cfg_bias_valid)
                        r_bias <= i_cfg_value[DW-1:0];

                    if (w_handshake)
                        r_prod <= '0;
                    else if (r_p1_vld)
                        r_prod <= w_w_ext * w_x_ext;

                    if (w_handshake)
                        r_acc <= '0;
                    else if (r_p2_vld)
                        r_acc <= sat_add(r_acc, r_prod);
                    else if (r_state == S_BIAS)
                        r_acc <= sat_add(r_acc, w_bias_ext);

                    if (r_state == S_ACT)
                        r_out <= w_act;
                end
            end

            assign o_out_data[g*DW +: DW] = r_out;
        end
    endgenerate

endmodule

// File: tb/tb_neuron_layer_array.sv
// Directed bench: three 2-lane, 4-input instances (relu, leaky, linear) share one stimulus stream.
// Latency: each frame's result is expected 4 edges after its last accepted sample.
// Backpressure: out_ready is held low to test hold behaviour, otherwise tied high.
module tb_neuron_layer_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_wv = 1'b0;
    logic        cfg_bv = 1'b0;
    logic [31:0] cfg_layer = '0;
    logic [31:0] cfg_neuron = '0;
    logic [31:0] cfg_val = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy_r, rdy_k, rdy_l;
    logic        vld_r, vld_k, vld_l;
    logic        busy_r, busy_k, busy_l;
    logic [31:0] dat_r, dat_k, dat_l;

    int checks = 0;
    int errors = 0;
    int t;
    int n;

    always #5 clk = ~clk;

    neuron_layer_array #(.LAYER_NO(1), .NUM_NEURONS(2), .NUM_INPUTS(4), .DATA_WIDTH(16),
                         .INT_BITS(4), .ACT_TYPE("relu"), .LEAK_SHIFT(3)) u_relu (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_weight_valid(cfg_wv), .i_cfg_bias_valid(cfg_bv),
        .i_cfg_layer_num(cfg_layer), .i_cfg_neuron_num(cfg_neuron), .i_cfg_value(cfg_val),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(rdy_r),
        .o_out_data(dat_r), .o_out_valid(vld_r), .i_out_ready(out_ready), .o_busy(busy_r));

    neuron_layer_array #(.LAYER_NO(1), .NUM_NEURONS(2), .NUM_INPUTS(4), .DATA_WIDTH(16),
                         .INT_BITS(4), .ACT_TYPE("leaky"), .LEAK_SHIFT(3)) u_leaky (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_weight_valid(cfg_wv), .i_cfg_bias_valid(cfg_bv),
        .i_cfg_layer_num(cfg_layer), .i_cfg_neuron_num(cfg_neuron), .i_cfg_value(cfg_val),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(rdy_k),
        .o_out_data(dat_k), .o_out_valid(vld_k), .i_out_ready(out_ready), .o_busy(busy_k));

    neuron_layer_array #(.LAYER_NO(1), .NUM_NEURONS(2), .NUM_INPUTS(4), .DATA_WIDTH(16),
                         .INT_BITS(4), .ACT_TYPE("linear"), .LEAK_SHIFT(3)) u_linear (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_weight_valid(cfg_wv), .i_cfg_bias_valid(cfg_bv),
        .i_cfg_layer_num(cfg_layer), .i_cfg_neuron_num(cfg_neuron), .i_cfg_value(cfg_val),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(rdy_l),
        .o_out_data(dat_l), .o_out_valid(vld_l), .i_out_ready(out_ready), .o_busy(busy_l));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_w(input int lane, input logic [15:0] v);
        cfg_layer = 32'd1; cfg_neuron = 32'(lane); cfg_val = {16'h0, v}; cfg_wv = 1'b1;
        @(posedge clk); #1;
        cfg_wv = 1'b0;
    endtask

    task automatic cfg_b(input int lane, input logic [15:0] v);
        cfg_layer = 32'd1; cfg_neuron = 32'(lane); cfg_val = {16'h0, v}; cfg_bv = 1'b1;
        @(posedge clk); #1;
        cfg_bv = 1'b0;
    endtask

    task automatic load_cfg(input logic [15:0] w0, input logic [15:0] b0,
                            input logic [15:0] w1, input logic [15:0] b1);
        for (int k = 0; k < 4; k++) cfg_w(0, w0);
        for (int k = 0; k < 4; k++) cfg_w(1, w1);
        cfg_b(0, b0);
        cfg_b(1, b1);
    endtask

    // Holds in_valid until an edge on which in_ready was high; returns edges taken.
    task automatic send(input logic [15:0] d, output int tries);
        logic rdy;
        in_valid = 1'b1; in_data = d; tries = 0;
        do begin
            rdy = rdy_r;
            @(posedge clk); #1;
            tries++;
        end while (!rdy && tries < 40);
        in_valid = 1'b0;
        if (!rdy) chk("accept_timeout", 64'(tries), 64'd1);
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!vld_r && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d,
                             input logic [31:0] er, input logic [31:0] ek, input logic [31:0] el);
        int tr;
        int lat;
        send(a, tr); send(b, tr); send(c, tr); send(d, tr);
        wait_out(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_relu"},   64'(dat_r), 64'(er));
        chk({tag, "_leaky"},  64'(dat_k), 64'(ek));
        chk({tag, "_linear"}, 64'(dat_l), 64'(el));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(rdy_r), 64'd1);
        chk("rst_out_valid", 64'(vld_r), 64'd0);
        chk("rst_out_data", 64'(dat_r), 64'd0);
        chk("rst_busy", 64'(busy_r), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        load_cfg(16'h1000, 16'h0800, 16'hF000, 16'h0800);

        // Frame 1 with the result held back by out_ready = 0
        out_ready = 1'b0;
        send(16'h1000, t);
        chk("accum_busy", 64'(busy_r), 64'd1);
        chk("accum_in_ready", 64'(rdy_r), 64'd1);
        send(16'h2000, t); send(16'h0800, t); send(16'h0800, t);
        chk("drain_busy", 64'(busy_r), 64'd1);
        chk("drain_in_ready", 64'(rdy_r), 64'd0);
        wait_out(n);
        chk("f1_latency", 64'(n), 64'd4);
        chk("f1_relu", 64'(dat_r), 64'h0000_4800);
        chk("f1_leaky", 64'(dat_k), 64'hF900_4800);
        chk("f1_linear", 64'(dat_l), 64'hC800_4800);

        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'h7777;
            @(posedge clk); #1;
            chk("bp_hold", {30'd0, vld_r, rdy_r, busy_r, dat_r}, {30'd0, 1'b1, 1'b0, 1'b1, 32'h0000_4800});
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", 64'(vld_r), 64'd0);
        chk("release_in_ready", 64'(rdy_r), 64'd1);
        send(16'h1000, t);
        chk("next_accept_edge", 64'(t), 64'd1);
        send(16'h2000, t); send(16'h0800, t); send(16'h0800, t);
        wait_out(n);
        chk("f2_latency", 64'(n), 64'd4);
        chk("f2_relu", 64'(dat_r), 64'h0000_4800);
        chk("f2_leaky", 64'(dat_k), 64'hF900_4800);
        @(posedge clk); #1;

        // Config writes while busy must be ignored
        send(16'h1000, t);
        cfg_layer = 32'd1; cfg_neuron = 32'd0; cfg_val = 32'h0000_7FFF;
        cfg_wv = 1'b1; cfg_bv = 1'b1;
        send(16'h2000, t); send(16'h0800, t); send(16'h0800, t);
        wait_out(n);
        cfg_wv = 1'b0; cfg_bv = 1'b0;
        chk("busycfg_latency", 64'(n), 64'd4);
        chk("busycfg_relu", 64'(dat_r), 64'h0000_4800);
        @(posedge clk); #1;

        // Wrong layer, then out-of-range lane
        cfg_layer = 32'd2; cfg_neuron = 32'd0; cfg_val = 32'h0000_7FFF;
        cfg_wv = 1'b1; cfg_bv = 1'b1;
        @(posedge clk); #1;
        cfg_layer = 32'd1; cfg_neuron = 32'd2;
        @(posedge clk); #1;
        cfg_wv = 1'b0; cfg_bv = 1'b0;
        run_frame("rerun", 16'h1000, 16'h2000, 16'h0800, 16'h0800,
                  32'h0000_4800, 32'hF900_4800, 32'hC800_4800);

        // Saturation of accumulator and output
        load_cfg(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_frame("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                  32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF);
        run_frame("sat_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                  32'h0000_0000, 32'h8000_8000, 32'h8000_8000);

        // Reset in the middle of a frame
        load_cfg(16'h1000, 16'h0800, 16'hF000, 16'h0800);
        run_frame("pre_rst", 16'h1000, 16'h2000, 16'h0800, 16'h0800,
                  32'h0000_4800, 32'hF900_4800, 32'hC800_4800);
        send(16'h1000, t); send(16'h2000, t);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(rdy_r), 64'd1);
        chk("midrst_out_valid", 64'(vld_r), 64'd0);
        chk("midrst_out_data", 64'(dat_r), 64'd0);
        chk("midrst_out_data_leaky", 64'(dat_k), 64'd0);
        chk("midrst_busy", 64'(busy_r), 64'd0);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_output", 64'({vld_r, busy_r}), 64'd0);

        // Biases are cleared by reset, weights are retained
        run_frame("nobias", 16'h1000, 16'h2000, 16'h0800, 16'h0800,
                  32'h0000_4000, 32'hF800_4000, 32'hC000_4000);
        cfg_b(0, 16'h0800);
        cfg_b(1, 16'h0800);
        run_frame("after_rst", 16'h1000, 16'h2000, 16'h0800, 16'h0800,
                  32'h0000_4800, 32'hF900_4800, 32'hC800_4800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
